// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment codes,
// converter state type and small helper functions.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } conv_state_t;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    unique case (nib)
      4'h0: code = SEG_0;
      4'h1: code = SEG_1;
      4'h2: code = SEG_2;
      4'h3: code = SEG_3;
      4'h4: code = SEG_4;
      4'h5: code = SEG_5;
      4'h6: code = SEG_6;
      4'h7: code = SEG_7;
      4'h8: code = SEG_8;
      4'h9: code = SEG_9;
      4'hA: code = SEG_A;
      4'hB: code = SEG_B;
      4'hC: code = SEG_C;
      4'hD: code = SEG_D;
      4'hE: code = SEG_E;
      4'hF: code = SEG_F;
    endcase
    return code;
  endfunction

  // Largest value that fits in n decimal digits; only ever called with constants.
  function automatic logic [39:0] dec_max(input int n);
    logic [39:0] m;
    m = 40'd1;
    for (int i = 0; i < n; i++) m = m * 40'd10;
    return m - 40'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, MSB first.
// state      | meaning
// ST_IDLE    | no conversion running, waiting for start
// ST_CONVERT | shifting value bits into the BCD accumulator
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int VALUE_W    = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [VALUE_W-1:0]      value,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(VALUE_W - 1);

  conv_state_t             state, state_next;
  logic [VALUE_W-1:0]      shreg, shreg_next;
  logic [4*NUM_DIGITS-1:0] acc, acc_next;
  logic [4*NUM_DIGITS-1:0] adj, step;
  logic [CNT_W-1:0]        cnt, cnt_next;

  always_comb begin
    adj = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    step = (adj << 1) | {{(4*NUM_DIGITS-1){1'b0}}, shreg[VALUE_W-1]};
  end

  // The result of the final step is offered combinationally so the caller can
  // capture it on the same edge the FSM returns to idle.
  assign bcd  = step;
  assign busy = (state == ST_CONVERT);

  always_comb begin
    state_next = state;
    shreg_next = shreg;
    acc_next   = acc;
    cnt_next   = cnt;
    done       = 1'b0;
    if (abort) begin
      state_next = ST_IDLE;
    end else if (start) begin
      state_next = ST_CONVERT;
      shreg_next = value;
      acc_next   = '0;
      cnt_next   = CNT_LOAD;
    end else if (state == ST_CONVERT) begin
      acc_next   = step;
      shreg_next = shreg << 1;
      if (cnt == '0) begin
        state_next = ST_IDLE;
        done       = 1'b1;
      end else begin
        cnt_next = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: rtl/seven_seg_mux.sv
// Multi-digit time-multiplexed seven-segment driver (decimal or hex display).
// Define SEVEN_SEG_LZB_EN to blank leading zero digits on display updates.
module seven_seg_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int VALUE_W    = 16,
  parameter int SCAN_DIV   = 16000,
  parameter int HEX_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  valid,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  busy,
  output logic                  overflow
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS*7-1:0] DASH_ALL = {NUM_DIGITS{SEG_DASH}};

  logic [63:0]             value_ext;
  logic                    too_big;
  logic                    start_conv, abort_conv;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic [NUM_DIGITS*7-1:0] disp;
  logic [CNT_W-1:0]        scan_cnt;
  logic [IDX_W-1:0]        scan_idx;

  function automatic logic [NUM_DIGITS*7-1:0] encode(input logic [4*NUM_DIGITS-1:0] nibs);
    logic [NUM_DIGITS*7-1:0] codes;
`ifdef SEVEN_SEG_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    codes = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
`ifdef SEVEN_SEG_LZB_EN
      if (lead && i != 0 && nibs[4*i +: 4] == 4'd0) begin
        codes[7*i +: 7] = SEG_BLANK;
      end else begin
        codes[7*i +: 7] = nibble_to_seg(nibs[4*i +: 4]);
        lead = 1'b0;
      end
`else
      codes[7*i +: 7] = nibble_to_seg(nibs[4*i +: 4]);
`endif
    end
    return codes;
  endfunction

  assign value_ext = 64'(value);

  always_comb begin
    if (HEX_MODE != 0) too_big = (value_ext >> (4 * NUM_DIGITS)) != 64'd0;
    else               too_big = value_ext > 64'(dec_max(NUM_DIGITS));
  end

  // Any load that does not start a new conversion cancels a running one.
  assign start_conv = load & valid & ~too_big & (HEX_MODE == 0);
  assign abort_conv = load & ~start_conv;

  bin2bcd_seq #(
    .VALUE_W   (VALUE_W),
    .NUM_DIGITS(NUM_DIGITS)
  ) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(start_conv),
    .abort(abort_conv),
    .value(value),
    .busy (busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      disp     <= DASH_ALL;
      overflow <= 1'b0;
    end else if (load) begin
      if (!valid) begin
        disp     <= DASH_ALL;
        overflow <= 1'b0;
      end else if (too_big) begin
        disp     <= DASH_ALL;
        overflow <= 1'b1;
      end else if (HEX_MODE != 0) begin
        disp     <= encode(value_ext[4*NUM_DIGITS-1:0]);
        overflow <= 1'b0;
      end
    end else if (conv_done) begin
      disp     <= encode(conv_bcd);
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
      seg      <= SEG_DASH;
      digit_en <= NUM_DIGITS'(1);
    end else begin
      seg      <= disp[7*scan_idx +: 7];
      digit_en <= NUM_DIGITS'(1) << scan_idx;
      if (scan_cnt == CNT_TC) begin
        scan_cnt <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_seg_mux.md
Name: seven_seg_mux

Overview:
- Multi-digit, time-multiplexed seven-segment display driver. Successor to the single-digit driver.
- Takes a binary value of parametrised width. Converts it to decimal sequentially (double-dabble, one bit per clock) or hex (direct nibble slicing), then scans the digits onto one shared segment bus.
- Sits between the stack-processor core (top-of-stack value plus stack-not-empty flag) and the board's digit/segment pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1-8.
- VALUE_W, 16, width of the input value; legal range 1-32.
- SCAN_DIV, 16000, clocks each digit stays enabled (1 ms at 16 MHz); must be >= 2.
- HEX_MODE, 0, selects the conversion: 0 = decimal, 1 = hexadecimal.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- value  in  VALUE_W  binary value to display
- valid  in  1  value is meaningful; when 0 the display shows "-" on every digit
- load  in  1  single-cycle strobe that samples value and valid
- seg  out  7  segments {a,b,c,d,e,f,g}: bit6 = a, bit0 = g; active-high
- digit_en  out  NUM_DIGITS  one-hot digit enable, active-high; bit0 = least-significant (rightmost) digit
- busy  out  1  decimal conversion in progress
- overflow  out  1  last loaded valid value does not fit in NUM_DIGITS digits

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - seg = 7'b0000001 (dash); digit_en = 1; busy = 0; overflow = 0.
  - Scan index = 0; scan counter = 0.
  - Display register holds the dash code on all digits.
- Segment codes:
  - Decimal digits: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Hex letters: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - Dash = 0000001. Blank = 0000000.
- Load handling: load is sampled every cycle.
  - load with valid=0: display register becomes all dash next cycle; overflow cleared; any running conversion aborted; busy=0.
  - load with valid=1 and an overflowing value: display register becomes all dash next cycle; overflow=1. Overflow means value > 10^NUM_DIGITS-1 (decimal) or value >> 4*NUM_DIGITS != 0 (hex).
  - load with valid=1, hex, no overflow: display register updated from nibbles next cycle; overflow=0; busy never asserts.
  - load with valid=1, decimal, no overflow:
    - FSM goes IDLE -> CONVERT; busy=1 from the next cycle for exactly VALUE_W cycles.
    - Each cycle: add-3 to every BCD nibble >= 5, then shift in one value bit, MSB first.
    - On the final cycle: FSM -> IDLE, display register written, busy=0 and overflow=0 from the next cycle.
  - Until the update, the display keeps its previous content.
- load during CONVERT: restarts with the new sample. Last load wins; no queueing.
- FSM states: IDLE, CONVERT. rst forces IDLE; a mid-conversion reset discards partial BCD.
- Scan:
  - Counter runs 0..SCAN_DIV-1 continuously, independent of load and busy.
  - At terminal count the index advances (NUM_DIGITS-1 wraps to 0).
  - seg and digit_en are registered: they reflect the index and display register with 1-cycle latency.
  - Exactly one digit_en bit is high at all times after reset.
- NUM_DIGITS=1: index stays 0; digit_en is constantly 1.

Optional Feature:
- SEVEN_SEG_LZB_EN: leading-zero blanking.
- Defined: on display-register update, zero digits above the most-significant nonzero digit are stored as blank. Digit 0 always shows. Value 0 shows a single "0".
- Undefined: all digits are shown, zero-padded. Dash and overflow display are unaffected either way.

Decomposition:
- Shared package seven_seg_pkg:
  - segment code constants (digits 0-F, SEG_DASH, SEG_BLANK);
  - FSM state typedef;
  - function nibble_to_seg(4-bit) -> 7-bit;
  - function dec_max(NUM_DIGITS) -> 10^NUM_DIGITS-1.
- One sub-module: bin2bcd_seq (sequential double-dabble; start/value in, busy/done/bcd out). The scan logic stays in the top module.

Test Plan:
- Reset, then 4 scan periods with no load -> digit_en cycles 0001, 0010, 0100, 1000, 0001 every SCAN_DIV=4 clocks; seg=0000001 throughout.
- Decimal: load value=1234, valid=1 -> busy high for 16 cycles; then digit3..0 show 1, 2, 3, 4 (0110000, 1101101, 1111001, 0110011); overflow=0.
- Decimal overflow: load value=10000 -> next cycle all digits dash, overflow=1, busy stays 0.
- Restart: load 1234, then load 42 after 5 cycles of busy -> busy high 16 cycles after the second load; final display 0042 (LZB off) or blank-blank-4-2 (SEVEN_SEG_LZB_EN on); 1234 never displayed.
- Hex (HEX_MODE=1): load 16'hBEEF -> next cycle digits b, E, E, F; busy never asserts. Then load with valid=0 -> all dash next cycle.
- Reset mid-conversion: load 9999, assert rst at busy cycle 8 -> busy=0, display all dash, digit_en=0001 the cycle after rst.
